// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute-stage ALU with a registered result and valid/ready
// handshakes on both sides.
// Build option: ALU_FAST_SHIFT_EN. When it is defined, SLL/SRL become single-cycle
// barrel shifts. When it is undefined (the default), SLL/SRL use an iterative
// shifter that moves one bit per cycle and stalls the front end while it runs.
module alu_exec_stage #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      tag_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic [4:0]      tag_out,
  output logic            busy
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;

  logic [SHW-1:0]  shamt_s;
  logic [XLEN-1:0] alu_res_s;
  logic            alu_ill_s;
  logic            accept_s;
  logic            load_s;
  logic            idle_s;
  logic            slt_s;

  logic [XLEN-1:0] result_r;
  logic            zero_r;
  logic            illegal_r;
  logic [4:0]      tag_r;
  logic            out_valid_r;

  assign shamt_s = op_b[SHW-1:0];
  assign slt_s   = ($signed(op_a) < $signed(op_b));

`ifndef ALU_FAST_SHIFT_EN
  localparam logic [0:0]     ST_IDLE  = 1'b0;
  localparam logic [0:0]     ST_SHIFT = 1'b1;
  localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
  localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  logic [0:0]      state_r;
  logic [SHW-1:0]  cnt_r;
  logic [XLEN-1:0] shreg_r;
  logic            dir_right_r;
  logic [4:0]      shift_tag_r;
  logic            start_shift_s;
  logic            shift_done_s;
  logic [XLEN-1:0] shift_next_s;

  assign idle_s       = (state_r == ST_IDLE);
  assign shift_done_s = (state_r == ST_SHIFT) && (cnt_r == CNT_ONE);
  assign busy         = (state_r == ST_SHIFT);

  // One-bit logical shift step of the iterative shifter, zero fill.
  always_comb begin
    shift_next_s = shreg_r;
    if (dir_right_r) begin
      shift_next_s = {1'b0, shreg_r[XLEN-1:1]};
    end else begin
      shift_next_s = {shreg_r[XLEN-2:0], 1'b0};
    end
  end
`else
  assign idle_s = 1'b1;
  assign busy   = 1'b0;
`endif

  assign in_ready = idle_s && (!out_valid_r || out_ready);
  assign accept_s = in_valid && in_ready;

  // Single-cycle operation result; a non-zero iterative shift is flagged instead.
  always_comb begin
    alu_res_s = {XLEN{1'b0}};
    alu_ill_s = 1'b0;
`ifndef ALU_FAST_SHIFT_EN
    start_shift_s = 1'b0;
`endif
    case (alu_control)
      OP_ADD: alu_res_s = op_a + op_b;
      OP_SUB: alu_res_s = op_a - op_b;
      OP_AND: alu_res_s = op_a & op_b;
      OP_OR:  alu_res_s = op_a | op_b;
      OP_XOR: alu_res_s = op_a ^ op_b;
      OP_SLT: alu_res_s = {{(XLEN-1){1'b0}}, slt_s};
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL: alu_res_s = op_a << shamt_s;
      OP_SRL: alu_res_s = op_a >> shamt_s;
`else
      OP_SLL: begin
        alu_res_s     = op_a;
        start_shift_s = (shamt_s != CNT_ZERO);
      end
      OP_SRL: begin
        alu_res_s     = op_a;
        start_shift_s = (shamt_s != CNT_ZERO);
      end
`endif
      default: begin
        alu_res_s = {XLEN{1'b0}};
        alu_ill_s = 1'b1;
      end
    endcase
  end

`ifndef ALU_FAST_SHIFT_EN
  assign load_s = accept_s && !start_shift_s;

  // Shift sequencer: latches a multi-cycle shift on accept and steps it to completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      shreg_r     <= {XLEN{1'b0}};
      dir_right_r <= 1'b0;
      shift_tag_r <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && start_shift_s) begin
            shreg_r     <= op_a;
            cnt_r       <= shamt_s;
            dir_right_r <= (alu_control == OP_SRL);
            shift_tag_r <= tag_in;
            state_r     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg_r <= shift_next_s;
          cnt_r   <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end
`else
  assign load_s = accept_s;
`endif

  // Output register: loads a new result (load wins over drain), otherwise drains on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r    <= {XLEN{1'b0}};
      zero_r      <= 1'b0;
      illegal_r   <= 1'b0;
      tag_r       <= 5'd0;
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      result_r    <= alu_res_s;
      zero_r      <= (alu_res_s == {XLEN{1'b0}});
      illegal_r   <= alu_ill_s;
      tag_r       <= tag_in;
      out_valid_r <= 1'b1;
`ifndef ALU_FAST_SHIFT_EN
    end else if (shift_done_s) begin
      result_r    <= shift_next_s;
      zero_r      <= (shift_next_s == {XLEN{1'b0}});
      illegal_r   <= 1'b0;
      tag_r       <= shift_tag_r;
      out_valid_r <= 1'b1;
`endif
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign result    = result_r;
  assign zero      = zero_r;
  assign illegal   = illegal_r;
  assign tag_out   = tag_r;
  assign out_valid = out_valid_r;

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute-stage ALU that consumes the 4-bit ALU control code produced by the decode-side control generator, together with the register operands, and produces a registered result for writeback/memory. Logic and arithmetic ops complete in one cycle. SLL/SRL run on an iterative 1-bit-per-cycle shifter unless the fast-shift build option is enabled. Valid/ready handshakes on both sides let the stage stall the front end during multi-cycle shifts and absorb writeback backpressure.

## Interface
- XLEN, 32: datapath width; must be a power of two ≥ 8.
- SHW, $clog2(XLEN): shift-amount width (5 for XLEN=32).

- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  stage accepts the operation this cycle
- alu_control  in  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRL; all other codes (including 1111) illegal
- op_a  in  XLEN  operand A / shift source
- op_b  in  XLEN  operand B; shift amount = op_b[SHW-1:0]
- tag_in  in  5  destination register index, passed through
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  consumer accepts result this cycle
- result  out  XLEN  registered result
- zero  out  1  result == 0
- illegal  out  1  result came from an illegal control code
- tag_out  out  5  tag of the result
- busy  out  1  iterative shift in progress

## Operation
- States: IDLE, SHIFT.
- in_ready = (state == IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Accept in IDLE, non-shift code, or shift with amount 0: result, zero, illegal, tag_out loaded on the same edge; out_valid ← 1; stay IDLE.
- Accept of SLL/SRL with amount N ≥ 1: shreg ← op_a, cnt ← N, shift direction and tag latched; state ← SHIFT.
- SHIFT, every edge: shreg shifted by 1 (SLL left, SRL right logical, zero fill); cnt ← cnt − 1. On the edge where cnt == 1: result ← shifted value, zero updated, illegal ← 0, out_valid ← 1, state ← IDLE.
- Output register is empty whenever SHIFT completes (acceptance required it empty or draining), so completion never stalls.
- out_valid clears on out_valid && out_ready unless a new result loads on the same edge (load wins, out_valid stays 1).
- Arithmetic: ADD/SUB modulo 2^XLEN, no carry/overflow outputs. SLT signed two's-complement compare, result 1 or 0 zero-extended. Shift amount uses only op_b[SHW-1:0]; upper bits ignored.
- Illegal code: result ← 0, zero ← 1, illegal ← 1, out_valid ← 1; consumer decides trap.
- busy = (state == SHIFT).

## Timing
- Reset: state IDLE, cnt 0, out_valid 0, result 0, zero 0, illegal 0, tag_out 0, busy 0. in_ready is 1 in the first cycle after reset.
- Reset mid-SHIFT abandons the operation; no result is produced.
- Latency (accept edge → out_valid high): 1 cycle for non-shift ops and shift amount 0; 1 + N cycles for shift amount N (max 1 + XLEN − 1).
- Throughput: one non-shift op per cycle with out_ready held high. in_ready low for the whole SHIFT occupancy.
- in_ready depends combinationally on out_ready; no other combinational input→output paths.

## Configuration
- ALU_FAST_SHIFT_EN defined: SLL/SRL are barrel shifts completing in 1 cycle like other ops; SHIFT state and counter removed; busy tied 0.
- Undefined (default): iterative shifter as described above.

## Test plan
- Reset then ADD 0x7FFFFFFF + 1 -> out_valid one cycle after accept, result 0x80000000, zero 0; SUB 5 − 5 -> result 0, zero 1.
- SLT with op_a 0xFFFFFFFF (−1), op_b 1 -> result 1; op_a 1, op_b 0xFFFFFFFF -> result 0.
- SLL op_a 0x1, op_b 0x24 (amount 4) -> in_ready low 4 cycles, busy high 4 cycles, out_valid 5 cycles after accept, result 0x10; SRL 0x80000000 by 31 -> result 0x1 after 32 cycles (iterative) or 1 cycle (ALU_FAST_SHIFT_EN).
- Back-to-back ADD/XOR/AND with out_ready low for 3 cycles -> first result held stable, in_ready low, no results lost or duplicated; tags emerge in order.
- Code 1111 and 1000 -> out_valid, illegal 1, result 0, zero 1; next legal op clears illegal.
- Assert rst two cycles into a 10-cycle SRL -> next cycle out_valid 0, busy 0, in_ready 1; no stale result appears afterwards.
